// File: rtl/nrisc_multiciclo.sv
// Multicycle nRISC core: 18-bit instructions, 8 registers with r0 tied to zero,
// and instruction/data memories reached over req/ack handshakes.
module nrisc_multiciclo #(
    parameter int          DATA_W   = 8,
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [17:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    input  logic [2:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [PC_W-1:0]   pc_out,
    output logic              retire,
    output logic              halted
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JUMP = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    state_t              state_q;
    logic                run_q;
    logic                retire_q;
    logic [PC_W-1:0]     pc_q;
    logic [17:0]         ir_q;
    logic [DATA_W-1:0]   a_q, b_q, alu_q, mdr_q;
    logic [DATA_W-1:0]   regs_q [8];
    logic [DATA_W-1:0]   alu_d;

    logic [2:0] op, rs, rt, rd, shamt, funct;
    logic [7:0] imm;
    logic [DATA_W-1:0] imm_sext;
    logic [PC_W-1:0]   pc_target;

    assign op        = ir_q[17:15];
    assign rs        = ir_q[14:12];
    assign rt        = ir_q[11:9];
    assign rd        = ir_q[8:6];
    assign shamt     = ir_q[5:3];
    assign funct     = ir_q[2:0];
    assign imm       = ir_q[7:0];
    assign imm_sext  = DATA_W'($signed(imm));
    assign pc_target = PC_W'(imm);

    always_comb begin
        alu_d = a_q + imm_sext;
        if (op == OP_R) begin
            case (funct)
                3'b000:  alu_d = a_q + b_q;
                3'b001:  alu_d = a_q - b_q;
                3'b010:  alu_d = a_q & b_q;
                3'b011:  alu_d = a_q | b_q;
                3'b100:  alu_d = a_q << shamt;
                3'b101:  alu_d = a_q >> shamt;
                3'b110:  alu_d = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
                default: alu_d = ~(a_q | b_q);
            endcase
        end
    end

    // run_q keeps imem_req low for the first cycle after reset is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            run_q    <= 1'b0;
            retire_q <= 1'b0;
            pc_q     <= PC_W'(RESET_PC);
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            run_q    <= 1'b1;
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (run_q && imem_ack) begin
                        ir_q    <= imem_rdata;
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= regs_q[rs];
                    b_q <= regs_q[rt];
                    if (op == OP_HALT) begin
                        state_q <= S_HALT;
                    end else if (op == OP_NOP) begin
                        state_q  <= S_FETCH;
                        retire_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q <= alu_d;
                    case (op)
                        OP_R, OP_ADDI: state_q <= S_WB;
                        OP_LW, OP_SW:  state_q <= S_MEM;
                        default: begin
                            if (op == OP_JUMP || (op == OP_BEQ && a_q == b_q)) pc_q <= pc_target;
                            state_q  <= S_FETCH;
                            retire_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_LW) begin
                            mdr_q   <= dmem_rdata;
                            state_q <= S_WB;
                        end else begin
                            state_q  <= S_FETCH;
                            retire_q <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (op == OP_R) begin
                        if (rd != 3'd0) regs_q[rd] <= alu_q;
                    end else if (rt != 3'd0) begin
                        regs_q[rt] <= (op == OP_LW) ? mdr_q : alu_q;
                    end
                    state_q  <= S_FETCH;
                    retire_q <= 1'b1;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req   = run_q && (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && (op == OP_SW);
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign dbg_rdata  = (dbg_raddr == 3'd0) ? '0 : regs_q[dbg_raddr];
    assign retire     = retire_q;
    assign halted     = (state_q == S_HALT);
endmodule
